// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch lap memory: controller states and
// default memory geometry.
package stopwatch_pkg;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef enum logic [2:0] {
        LIVE    = 3'd0,
        WRITE   = 3'd1,
        RD_WAIT = 3'd2,
        SHOW    = 3'd3,
        CLEAR   = 3'd4
    } state_e;

endpackage

// File: rtl/wrap_counter.sv
// Up/down counter with a programmable upper limit that wraps at both ends;
// exposes its next value so callers can register outputs derived from it.
module wrap_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count_q,
    output logic [W-1:0] count_d
);

    always_comb begin
        count_d = count_q;
        if (load_en) begin
            count_d = load_val;
        end else if (inc && !dec) begin
            count_d = (count_q == limit) ? '0 : count_q + 1'b1;
        end else if (dec && !inc) begin
            count_d = (count_q == '0) ? limit : count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lap_mem_ctrl.sv
// Lap memory controller: captures live time into a small BRAM, recalls laps
// for display, and sweeps the memory to zero on clear. Moore, registered outputs.
module lap_mem_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = stopwatch_pkg::DEPTH,
    parameter int AW    = stopwatch_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          store,
    input  logic          load,
    input  logic          next,
    input  logic          prev,
    input  logic          clear,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic          zero_din,
    output logic          select,
    output logic          mem_valid,
    output logic [AW:0]   lap_count,
    output logic          full,
    output logic          busy
);

    if (DEPTH != 2 ** AW) begin : g_bad_geometry
        $error("lap_mem_ctrl: DEPTH must equal 2**AW");
    end

    localparam logic [AW:0]   LAP_MAX    = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] SWEEP_LAST = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   lap_count_q, lap_count_d;
    logic [AW-1:0] sweep_q, sweep_d;

    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          zero_din_q, zero_din_d;
    logic          select_q, select_d;
    logic          mem_valid_q, mem_valid_d;
    logic          full_q, full_d;
    logic          busy_q, busy_d;

    logic          rd_load, rd_inc, rd_dec;
    logic [AW-1:0] rd_last;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;

    // Newest stored lap; only meaningful while lap_count > 0.
    assign rd_last = AW'(lap_count_q - 1'b1);

    wrap_counter #(
        .W(AW)
    ) u_rd_ptr (
        .clk     (clk),
        .rst     (reset),
        .load_en (rd_load),
        .load_val(rd_last),
        .inc     (rd_inc),
        .dec     (rd_dec),
        .limit   (rd_last),
        .count_q (rd_ptr_q),
        .count_d (rd_ptr_d)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        lap_count_d = lap_count_q;
        sweep_d     = sweep_q;
        rd_load     = 1'b0;
        rd_inc      = 1'b0;
        rd_dec      = 1'b0;

        unique case (state_q)
            LIVE: begin
                if (clear) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                end else if (load) begin
                    // A load with nothing stored still masks a simultaneous store.
                    if (lap_count_q != '0) begin
                        state_d = RD_WAIT;
                        rd_load = 1'b1;
                    end
                end else if (store && !full_q) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                wr_ptr_d    = wr_ptr_q + 1'b1;
                lap_count_d = lap_count_q + 1'b1;
                state_d     = LIVE;
            end
            RD_WAIT: begin
                if (clear) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                end else begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (clear) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                end else if (load) begin
                    state_d = LIVE;
                end else if (!store && (next ^ prev)) begin
                    rd_dec  = next;
                    rd_inc  = prev;
                    state_d = RD_WAIT;
                end
            end
            CLEAR: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == SWEEP_LAST) begin
                    state_d     = LIVE;
                    wr_ptr_d    = '0;
                    lap_count_d = '0;
                end
            end
            default: begin
                state_d = LIVE;
            end
        endcase
    end

    // Outputs are decoded from the next registered state so they change on the
    // same edge as the state itself.
    always_comb begin
        we_d        = (state_d == WRITE) || (state_d == CLEAR);
        zero_din_d  = (state_d == CLEAR);
        select_d    = (state_d == RD_WAIT) || (state_d == SHOW);
        mem_valid_d = (state_d == SHOW);
        busy_d      = (state_d == WRITE) || (state_d == CLEAR);
        full_d      = (lap_count_d == LAP_MAX);
        if (state_d == CLEAR) begin
            addr_d = sweep_d;
        end else if (select_d) begin
            addr_d = rd_ptr_d;
        end else begin
            addr_d = wr_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LIVE;
            wr_ptr_q    <= '0;
            lap_count_q <= '0;
            sweep_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            zero_din_q  <= 1'b0;
            select_q    <= 1'b0;
            mem_valid_q <= 1'b0;
            full_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            lap_count_q <= lap_count_d;
            sweep_q     <= sweep_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            zero_din_q  <= zero_din_d;
            select_q    <= select_d;
            mem_valid_q <= mem_valid_d;
            full_q      <= full_d;
            busy_q      <= busy_d;
        end
    end

    assign we        = we_q;
    assign addr      = addr_q;
    assign zero_din  = zero_din_q;
    assign select    = select_q;
    assign mem_valid = mem_valid_q;
    assign lap_count = lap_count_q;
    assign full      = full_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lap_mem_ctrl.sv
// Directed bench for lap_mem_ctrl: a mode-level reference model is checked on
// every falling edge, with literal expectations at the key scenario points.
module tb_lap_mem_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       store = 1'b0, load = 1'b0, next = 1'b0, prev = 1'b0, clear = 1'b0;
    logic       we, zero_din, select, mem_valid, full, busy;
    logic [3:0] addr;
    logic [4:0] lap_count;

    int n_checks = 0;
    int n_errors = 0;
    bit run_chk  = 1'b0;

    // Reference model: 0 live, 1 writing, 2 waiting for read, 3 showing, 4 clearing.
    int m_mode = 0, m_laps = 0, m_wp = 0, m_rp = 0, m_sweep = 0;

    lap_mem_ctrl #(.DEPTH(16), .AW(4)) dut (
        .clk(clk), .reset(reset), .store(store), .load(load), .next(next),
        .prev(prev), .clear(clear), .we(we), .addr(addr), .zero_din(zero_din),
        .select(select), .mem_valid(mem_valid), .lap_count(lap_count),
        .full(full), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_laps = 0; m_wp = 0; m_rp = 0; m_sweep = 0;
        end else begin
            case (m_mode)
                0: if (clear) begin m_mode = 4; m_sweep = 0; end
                   else if (load) begin
                       if (m_laps > 0) begin m_mode = 2; m_rp = m_laps - 1; end
                   end else if (store && m_laps < 16) m_mode = 1;
                1: begin m_wp = (m_wp + 1) % 16; m_laps++; m_mode = 0; end
                2: if (clear) begin m_mode = 4; m_sweep = 0; end else m_mode = 3;
                3: if (clear) begin m_mode = 4; m_sweep = 0; end
                   else if (load) m_mode = 0;
                   else if (!store && next && !prev) begin m_rp = (m_rp + m_laps - 1) % m_laps; m_mode = 2; end
                   else if (!store && prev && !next) begin m_rp = (m_rp + 1) % m_laps; m_mode = 2; end
                4: begin
                       m_sweep++;
                       if (m_sweep == 16) begin m_mode = 0; m_wp = 0; m_laps = 0; end
                   end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (run_chk && !reset) begin
            chk("m_we",        we,        int'(m_mode == 1 || m_mode == 4));
            chk("m_busy",      busy,      int'(m_mode == 1 || m_mode == 4));
            chk("m_zero_din",  zero_din,  int'(m_mode == 4));
            chk("m_select",    select,    int'(m_mode == 2 || m_mode == 3));
            chk("m_mem_valid", mem_valid, int'(m_mode == 3));
            chk("m_lap_count", lap_count, m_laps);
            chk("m_full",      full,      int'(m_laps == 16));
            chk("m_addr",      addr,      (m_mode == 4) ? m_sweep : ((m_mode == 2 || m_mode == 3) ? m_rp : m_wp));
        end
    end

    task automatic pulse(input bit s, input bit l, input bit n, input bit p, input bit c);
        store = s; load = l; next = n; prev = p; clear = c;
        @(posedge clk);
        #1;
        store = 0; load = 0; next = 0; prev = 0; clear = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_zero_din"}, zero_din, 0);
        chk({tag, "_select"}, select, 0);
        chk({tag, "_mem_valid"}, mem_valid, 0);
        chk({tag, "_lap_count"}, lap_count, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #3;
        chk_reset_outputs("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_chk = 1'b1;
        idle(1);

        // Three stores: single-cycle we at 0, 1, 2.
        for (int k = 0; k < 3; k++) begin
            pulse(1, 0, 0, 0, 0);
            chk("st3_we", we, 1);
            chk("st3_addr", addr, k);
            idle(1);
            chk("st3_we_off", we, 0);
        end
        chk("st3_count", lap_count, 3);
        chk("st3_full", full, 0);

        // Recall and step through the laps.
        pulse(0, 1, 0, 0, 0);
        chk("ld_select", select, 1);
        chk("ld_valid0", mem_valid, 0);
        chk("ld_addr", addr, 2);
        idle(1);
        chk("ld_valid1", mem_valid, 1);
        pulse(0, 0, 1, 0, 0); idle(1); chk("next1_addr", addr, 1);
        pulse(0, 0, 1, 0, 0); idle(1); chk("next2_addr", addr, 0);
        pulse(0, 0, 1, 0, 0); idle(1); chk("next3_addr", addr, 2);
        pulse(0, 0, 0, 1, 0); idle(1); chk("prev_addr", addr, 0);
        chk("prev_valid", mem_valid, 1);
        pulse(0, 0, 1, 1, 0);
        chk("np_both_valid", mem_valid, 1);
        chk("np_both_addr", addr, 0);
        pulse(1, 0, 0, 0, 0);
        chk("show_store_we", we, 0);
        pulse(0, 1, 0, 0, 0);
        chk("back_live_select", select, 0);
        chk("back_live_addr", addr, 3);

        // Two more stores, then clear with five laps.
        pulse(1, 0, 0, 0, 0); idle(1);
        pulse(1, 0, 0, 0, 0); idle(1);
        chk("five_count", lap_count, 5);
        pulse(0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            chk("clr_we", we, 1);
            chk("clr_zero", zero_din, 1);
            chk("clr_busy", busy, 1);
            chk("clr_addr", addr, i);
            if (i < 15) idle(1);
        end
        idle(1);
        chk("clr_done_count", lap_count, 0);
        chk("clr_done_busy", busy, 0);
        chk("clr_done_we", we, 0);

        // Load while empty is ignored; clear wins over load and store.
        pulse(0, 1, 0, 0, 0);
        chk("empty_ld_select", select, 0);
        chk("empty_ld_busy", busy, 0);
        pulse(1, 1, 0, 0, 1);
        chk("prio_zero", zero_din, 1);
        chk("prio_select", select, 0);
        chk("prio_addr", addr, 0);
        idle(16);
        chk("prio_done_busy", busy, 0);

        // Fill the memory; the 17th store is dropped.
        for (int k = 0; k < 17; k++) begin
            pulse(1, 0, 0, 0, 0);
            if (k < 16) begin
                chk("fill_we", we, 1);
                chk("fill_addr", addr, k);
            end else begin
                chk("fill_17_we", we, 0);
            end
            idle(1);
            if (k == 15) chk("fill_full", full, 1);
        end
        chk("fill_count", lap_count, 16);
        pulse(0, 1, 0, 0, 0); idle(1);
        chk("full_ld_addr", addr, 15);
        pulse(0, 0, 0, 1, 0); idle(1);
        chk("full_prev_wrap", addr, 0);

        // Reset part-way through a sweep takes effect without a clock edge.
        pulse(0, 0, 0, 0, 1);
        idle(7);
        chk("mid_clr_addr", addr, 7);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);
        chk("post_rst_count", lap_count, 0);
        chk("post_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lap_mem_ctrl.md
LAP_MEM_CTRL -- requirements
Module: lap_mem_ctrl

Interface
REQ-001 Parameter DEPTH, 16, number of lap-memory entries.
REQ-002 Parameter AW, 4, memory address width; DEPTH SHALL equal 2**AW.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 store  input  1  one-cycle pulse (already debounced) requesting capture of the live time.
REQ-006 load  input  1  one-cycle pulse toggling between live view and recall view.
REQ-007 next  input  1  one-cycle pulse stepping recall to the next-older lap.
REQ-008 prev  input  1  one-cycle pulse stepping recall to the next-newer lap.
REQ-009 clear  input  1  one-cycle pulse erasing all laps.
REQ-010 we  output  1  memory write enable.
REQ-011 addr  output  AW  memory address.
REQ-012 zero_din  output  1  forces memory data-in to 0 when high.
REQ-013 select  output  1  display mux select: 0 is live counter, 1 is memory.
REQ-014 mem_valid  output  1  memory read data is valid for the displayed lap.
REQ-015 lap_count  output  AW+1  number of stored laps, 0..DEPTH.
REQ-016 full  output  1  high when lap_count == DEPTH.
REQ-017 busy  output  1  high in WRITE and CLEAR.

Function
REQ-018 FSM states SHALL be LIVE, WRITE, RD_WAIT, SHOW and CLEAR; all outputs SHALL be decoded from registered state and pointers only (Moore, no input-to-output combinational path).
REQ-019 Input priority in any cycle SHALL be clear > load > store > next/prev; next and prev asserted together SHALL be ignored.
REQ-020 LIVE: select=0, we=0, addr=wr_ptr; store with !full -> WRITE; store with full -> ignored; load with lap_count>0 -> RD_WAIT with rd_ptr=lap_count-1; load with lap_count==0 -> ignored.
REQ-021 WRITE: exactly one cycle with we=1, addr=wr_ptr; on exit wr_ptr+=1 and lap_count+=1 -> LIVE.
REQ-022 RD_WAIT: select=1, mem_valid=0, addr=rd_ptr for one cycle (BRAM read latency 1) -> SHOW.
REQ-023 SHOW: select=1, mem_valid=1, addr=rd_ptr; load -> LIVE; store ignored.
REQ-024 In SHOW, next sets rd_ptr to rd_ptr-1, wrapping from 0 to lap_count-1, then -> RD_WAIT.
REQ-025 In SHOW, prev sets rd_ptr to rd_ptr+1, wrapping from lap_count-1 to 0, then -> RD_WAIT.
REQ-026 clear from LIVE, RD_WAIT or SHOW -> CLEAR: we=1, zero_din=1, select=0; addr sweeps 0..DEPTH-1, one per cycle, for DEPTH cycles; then wr_ptr=0, lap_count=0 -> LIVE.
REQ-027 All inputs SHALL be ignored in WRITE and CLEAR.
REQ-028 full SHALL equal (lap_count == DEPTH); when lap_count == DEPTH, wr_ptr SHALL wrap to 0 but SHALL NOT be used until after a clear.

Reset
REQ-029 Reset SHALL force state=LIVE, wr_ptr=0, rd_ptr=0, lap_count=0, we=0, addr=0, zero_din=0, select=0, mem_valid=0, full=0, busy=0, asynchronously.
REQ-030 Reset during CLEAR SHALL abort the sweep; memory contents are then unspecified, and lap_count=0 guarantees they are never displayed.

Structure
REQ-031 Package stopwatch_pkg SHALL hold the state enum, DEPTH and AW.
REQ-032 rd_ptr SHALL be a sub-module wrap_counter (up/down, programmable limit, wrap at both ends); wr_ptr and sweep use plain counters in lap_mem_ctrl.

Verification
REQ-033 Reset, then 3 store pulses -> 3 single-cycle we pulses at addr 0,1,2; lap_count=3; full=0.
REQ-034 17 store pulses from empty -> 16 we pulses at addr 0..15; full=1 after the 16th; 17th pulse produces no we.
REQ-035 lap_count=3, load -> one cycle select=1 with mem_valid=0 at addr=2, then mem_valid=1; next x3 -> addr 1,0,2; prev -> addr 0.
REQ-036 load with lap_count=0 -> no state change, select stays 0; clear+load+store in the same cycle -> CLEAR only.
REQ-037 clear with lap_count=5 -> 16 consecutive cycles with we=1, zero_din=1, addr 0..15, busy=1; then lap_count=0, state LIVE.
REQ-038 Reset asserted mid-clear at addr=7 -> all outputs at reset values immediately, without waiting for a clock edge.
